// File: rtl/shift_deser.sv
// Serial-to-parallel collector: gathers MSB-first 1-bit or SYM-bit symbols into
// WIDTH-bit words and presents them through a one-entry valid/ready output register.
module shift_deser #(
  parameter int  WIDTH = 64,
  parameter int  SYM   = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [SYM-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    fill,
  output logic             err
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [CW-1:0] FILL_FULL     = CW'(WIDTH);
  localparam logic [CW-1:0] FILL_MAX_BYTE = CW'(WIDTH - SYM);
  localparam logic [CW-1:0] SYM_BITS      = CW'(SYM);

  if (((WIDTH % SYM) != 0) || (WIDTH < 2 * SYM)) begin : g_bad_params
    $error("shift_deser: WIDTH must be a multiple of SYM and at least 2*SYM");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    fill_d;
  logic             err_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_d;

  logic [WIDTH-1:0] acc_shift;
  logic [CW-1:0]    fill_inc;
  logic             accept;
  logic             out_pop;
  logic             misalign;
  logic             slot_free;

  // in_ready decodes registered state only, so no path from out_ready to in_ready.
  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign out_pop   = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign misalign  = in_mode && (fill > FILL_MAX_BYTE);

  // Candidate accumulator and fill after accepting the current symbol.
  always_comb begin
    acc_shift = acc_q;
    fill_inc  = fill;
    if (in_mode) begin
      acc_shift = {acc_q[WIDTH-SYM-1:0], in_data};
      fill_inc  = fill + SYM_BITS;
    end else begin
      acc_shift = {acc_q[WIDTH-2:0], in_data[0]};
      fill_inc  = fill + CW'(1);
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill;
    err_d       = err;
    out_valid_d = out_valid;
    out_data_d  = out_data;

    // A pop empties the slot unless a new word lands in the same cycle.
    if (out_pop) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      state_d = COLLECT;
      acc_d   = '0;
      fill_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (misalign) begin
              err_d = 1'b1;
            end else if (fill_inc == FILL_FULL) begin
              if (slot_free) begin
                out_data_d  = acc_shift;
                out_valid_d = 1'b1;
                acc_d       = '0;
                fill_d      = '0;
              end else begin
                acc_d   = acc_shift;
                fill_d  = FILL_FULL;
                state_d = HOLD;
              end
            end else begin
              acc_d  = acc_shift;
              fill_d = fill_inc;
            end
          end
        end
        HOLD: begin
          if (out_pop) begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
            state_d     = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      acc_q     <= '0;
      fill      <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fill      <= fill_d;
      err       <= err_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

  a_fill_range: assert property (@(posedge clk) disable iff (rst) fill <= FILL_FULL);
  a_hold_full:  assert property (@(posedge clk) disable iff (rst)
                                 (state_q == HOLD) |-> (fill == FILL_FULL && out_valid));

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: vector table, directed multi-cycle sequences and random
// traffic compared every cycle against a bit-queue reference model.
module tb_shift_deser;
  localparam int W  = 64;
  localparam int S  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic [S-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] fill;
  logic          err;

  int checks = 0;
  int errors = 0;

  shift_deser #(.WIDTH(W), .SYM(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the accumulator is simply the ordered list of received bits.
  bit           mbits[$];
  bit           m_hold;
  bit           m_ov;
  bit           m_err;
  logic [W-1:0] m_od;

  function automatic logic [W-1:0] pack();
    logic [W-1:0] w = '0;
    foreach (mbits[i]) w = {w[W-2:0], mbits[i]};
    return w;
  endfunction

  task automatic model_reset();
    mbits.delete();
    m_hold = 1'b0;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    m_od   = '0;
  endtask

  task automatic model_step();
    bit ov0    = m_ov;
    bit pop    = m_ov && out_ready;
    bit acc_ok = in_valid && !m_hold;
    if (clear) begin
      mbits.delete();
      m_err  = 1'b0;
      m_hold = 1'b0;
      if (pop) m_ov = 1'b0;
    end else if (m_hold) begin
      if (pop) begin
        m_od = pack();
        mbits.delete();
        m_hold = 1'b0;
      end
    end else begin
      if (pop) m_ov = 1'b0;
      if (acc_ok) begin
        if (in_mode && mbits.size() > W - S) begin
          m_err = 1'b1;
        end else begin
          if (in_mode) for (int i = S - 1; i >= 0; i--) mbits.push_back(in_data[i]);
          else mbits.push_back(in_data[0]);
          if (mbits.size() == W) begin
            if (!ov0 || out_ready) begin
              m_od = pack();
              m_ov = 1'b1;
              mbits.delete();
            end else begin
              m_hold = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    check("model.in_ready",  64'(in_ready),  64'(!m_hold));
    check("model.out_valid", 64'(out_valid), 64'(m_ov));
    check("model.out_data",  out_data,       m_od);
    check("model.fill",      64'(fill),      64'(mbits.size()));
    check("model.err",       64'(err),       64'(m_err));
  endtask

  // One clock: advance the model with the inputs the DUT will sample, then compare.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        clr;
    logic        vld;
    logic        mode;
    logic [7:0]  data;
    int          fill;
    logic        ov;
    logic        er;
    logic [63:0] od;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic clr, vld, mode, input logic [7:0] data,
                              input int fill_e, input logic ov, er, input logic [63:0] od);
    vec_t v;
    v.clr = clr; v.vld = vld; v.mode = mode; v.data = data;
    v.fill = fill_e; v.ov = ov; v.er = er; v.od = od;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [63:0] w1 = 64'h0102030405060708;
    logic [63:0] w3 = 64'hBFFFFFFFFFFFFFF1;
    logic [3:0]  pre = 4'b1011;
    logic [3:0]  post = 4'b0001;
    logic [63:0] wc = 64'hC0C1C2C3C4C5C6C7;

    // Byte stream, then the misalignment sequence, then a clear.
    for (int b = 1; b <= 8; b++)
      add(1'b0, 1'b1, 1'b1, 8'(b), (b == 8) ? 0 : b * 8, b == 8, 1'b0, (b == 8) ? w1 : 64'h0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, w1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, 1'b0, {7'h0, pre[3-i]}, i + 1, 1'b0, 1'b0, w1);
    for (int i = 0; i < 7; i++)
      add(1'b0, 1'b1, 1'b1, 8'hFF, 12 + 8 * i, 1'b0, 1'b0, w1);
    add(1'b0, 1'b1, 1'b1, 8'h12, 60, 1'b0, 1'b1, w1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, 1'b0, {7'h0, post[3-i]}, (i == 3) ? 0 : 61 + i, i == 3, 1'b1,
          (i == 3) ? w3 : w1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, w3);
    add(1'b1, 1'b1, 1'b1, 8'h55, 0, 1'b0, 1'b0, w3);

    // Reset state.
    model_reset();
    rst = 1'b1;
    #12;
    check("reset.in_ready",  64'(in_ready),  64'h1);
    check("reset.out_valid", 64'(out_valid), 64'h0);
    check("reset.out_data",  out_data,       64'h0);
    check("reset.fill",      64'(fill),      64'h0);
    check("reset.err",       64'(err),       64'h0);
    rst = 1'b0;

    out_ready = 1'b1;
    foreach (tbl[i]) begin
      clear    = tbl[i].clr;
      in_valid = tbl[i].vld;
      in_mode  = tbl[i].mode;
      in_data  = tbl[i].data;
      cyc();
      check($sformatf("tbl[%0d].fill", i),      64'(fill),      64'(tbl[i].fill));
      check($sformatf("tbl[%0d].out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      check($sformatf("tbl[%0d].err", i),       64'(err),       64'(tbl[i].er));
      check($sformatf("tbl[%0d].out_data", i),  out_data,       tbl[i].od);
    end
    clear    = 1'b0;
    in_valid = 1'b0;

    // Alternating bit stream.
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = (i % 2 == 0) ? 8'h01 : 8'h00;
      cyc();
      check("bits.fill", 64'(fill), (i < 63) ? 64'(i + 1) : 64'h0);
    end
    in_valid = 1'b0;
    check("bits.out_valid", 64'(out_valid), 64'h1);
    check("bits.out_data",  out_data,       64'hAAAAAAAAAAAAAAAA);

    // Backpressure into HOLD, then a single pop.
    out_ready = 1'b1;
    cyc();
    check("bp.drain", 64'(out_valid), 64'h0);
    out_ready = 1'b0;
    for (int b = 0; b < 16; b++) send_byte(8'(b));
    check("bp.hold.out_data", out_data,       64'h0001020304050607);
    check("bp.hold.in_ready", 64'(in_ready),  64'h0);
    check("bp.hold.fill",     64'(fill),      64'd64);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("bp.pop.out_data",  out_data,       64'h08090A0B0C0D0E0F);
    check("bp.pop.out_valid", 64'(out_valid), 64'h1);
    check("bp.pop.in_ready",  64'(in_ready),  64'h1);
    check("bp.pop.fill",      64'(fill),      64'h0);

    // Asynchronous reset between clock edges, mid-word.
    for (int b = 0; b < 3; b++) send_byte(8'h11 + 8'(b));
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.out_valid", 64'(out_valid), 64'h0);
    check("arst.fill",      64'(fill),      64'h0);
    check("arst.err",       64'(err),       64'h0);
    check("arst.out_data",  out_data,       64'h0);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) send_byte(8'hA0 + 8'(b));
    check("arst.word.valid", 64'(out_valid), 64'h1);
    check("arst.word.data",  out_data,       64'hA0A1A2A3A4A5A6A7);

    // Clear with a pending output word and a symbol presented alongside.
    cyc();
    out_ready = 1'b0;
    for (int b = 0; b < 8; b++) send_byte(8'hC0 + 8'(b));
    check("clr.word", out_data, wc);
    for (int b = 0; b < 3; b++) send_byte(8'h33);
    check("clr.pre.fill", 64'(fill), 64'd24);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_data  = 8'h77;
    cyc();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr.fill",      64'(fill),      64'h0);
    check("clr.out_data",  out_data,       wc);
    check("clr.out_valid", 64'(out_valid), 64'h1);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_mode   = ($urandom_range(0, 3) == 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 79) == 0);
      cyc();
    end
    in_valid = 1'b0;
    clear    = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-to-parallel collector and receive end of the 64-bit shift-out path. Shift-out emits MSB first, 1 bit or 8 bits per step; this block rebuilds the words.
- Accepts 1-bit or 8-bit symbols MSB-first through a valid/ready handshake.
- Left-shifts symbols into a WIDTH-bit accumulator and hands each completed word to a one-entry output register with its own valid/ready handshake.
- Sits between the serial link front-end and word-wide consumers (register file loaders, DMA staging).

Parameters:
WIDTH, 64, assembled word width in bits; must be a multiple of SYM and at least 2*SYM
SYM, 8, symbol width in byte mode
CW, $clog2(WIDTH+1), fill-counter width (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
clear  input  1  synchronous flush of accumulator, fill count and err; output register untouched
in_valid  input  1  input symbol valid
in_ready  output  1  block can accept a symbol this cycle
in_mode  input  1  0 = 1-bit symbol (in_data[0]), 1 = SYM-bit symbol (in_data)
in_data  input  SYM  symbol payload, MSB first
out_valid  output  1  out_data holds a complete word
out_ready  input  1  consumer takes the word this cycle
out_data  output  WIDTH  assembled word; first received bit sits in bit WIDTH-1
fill  output  CW  bits currently held in the accumulator, 0..WIDTH
err  output  1  sticky misalignment flag

Behaviour:
- Reset (async assert, sync release): acc=0, fill=0, state=COLLECT, out_valid=0, out_data=0, err=0.
- Accept means in_valid && in_ready. out_pop means out_valid && out_ready.
- States: COLLECT (in_ready=1) and HOLD (in_ready=0, fill=WIDTH, acc holds a full word).
- Bit mode accept:
  - acc <= {acc[WIDTH-2:0], in_data[0]}
  - fill <= fill+1
- Byte mode accept:
  - acc <= {acc[WIDTH-SYM-1:0], in_data}
  - fill <= fill+SYM
- Misalignment: byte-mode accept with fill > WIDTH-SYM.
  - Symbol is consumed but dropped; acc and fill are unchanged.
  - err <= 1, held until rst or clear.
- Completion: an accept that brings fill_next to WIDTH.
  - Slot free (!out_valid || out_ready): out_data <= acc_next, out_valid <= 1, acc <= 0, fill <= 0, stay in COLLECT. out_valid is seen the cycle after the last symbol is accepted.
  - Slot busy: acc <= acc_next, fill <= WIDTH, go to HOLD.
- HOLD handling: on out_pop, out_data <= acc, out_valid stays 1, acc <= 0, fill <= 0, go to COLLECT. in_ready is 1 on the following cycle.
- Pop with no new word: out_valid <= 0; out_data keeps its last value.
- Simultaneous pop and completion in the same cycle: the new word replaces the old, out_valid stays 1, nothing is lost.
- clear:
  - Has priority over any accept in the same cycle; the symbol is dropped.
  - Sets acc=0, fill=0, err=0, state=COLLECT.
  - A word already in HOLD is discarded.
  - out_valid and out_data are preserved, and out_pop is still honoured in that cycle.
- rst mid-word discards everything, including the output register.
- in_ready is registered state only; it does not depend combinationally on out_ready.

Test Plan:
1. Byte stream, out_ready=1: bytes 0x01..0x08 on consecutive cycles -> out_valid=1 for exactly one cycle, the cycle after byte 8; out_data=0x0102030405060708; fill returns to 0.
2. Bit stream: 64 bit-mode symbols alternating 1,0 starting with 1 -> out_data=0xAAAAAAAAAAAAAAAA; fill counts 1..63 before wrapping to 0.
3. Misalignment: send 4 bits (1,0,1,1), 7 bytes 0xFF (fill=60), then byte 0x12 -> err=1, fill stays 60. Then 4 bits 0,0,0,1 -> out_data=0xBFFFFFFFFFFFFFF1; err stays 1 until clear.
4. Backpressure, out_ready=0: send 16 bytes 0x00..0x0F -> word 1 (0x0001020304050607) in out_data, state HOLD, in_ready=0, fill=64. Pulse out_ready for one cycle -> next cycle out_data=0x08090A0B0C0D0E0F, out_valid=1, in_ready=1, fill=0.
5. Async reset mid-word: after 3 bytes, assert rst between clock edges -> out_valid=0, fill=0, err=0 immediately. Then 8 bytes 0xA0..0xA7 -> out_data=0xA0A1A2A3A4A5A6A7.
6. clear with a pending word, out_ready=0: out_valid=1 with word W and fill=24; pulse clear together with in_valid -> fill=0, symbol dropped, out_data still W, out_valid still 1.
